control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired Moore sequencer that generates every control input of the CPU datapath (register strobes, bus-out selects, Gra/Grb/Grc/Rin/Rout/BAout, Read/Write, IncPC, CONin).
- Runs fetch (T0–T2), then per-opcode execute steps (T3–T7).
- Reads the opcode from IR[31:27] and the CON flip-flop result back from the datapath.
- Sits beside the datapath; together they form the CPU top.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- NREG, 16, general register count (width of R0_15_in_enable_out).

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset; synchronous, active-high.
- opcode  in  5  IR[31:27]; valid from T3 onward.
- con_ff  in  1  branch condition from the CON FF.
- stop  in  1  pause request, sampled at instruction end.
- run  out  1  high when sequencing; low in S_RESET, S_PAUSE, S_HALT.
- Read, Write, IncPC, CONin  out  1 each  memory and PC controls.
- PC_enable, Z_enable, MDR_enable, MAR_enable, Y_enable, HI_enable, LO_enable, IR_enable, OutPort_enable  out  1 each  register load strobes.
- PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout, BAout  out  1 each  bus source selects.
- Gra, Grb, Grc, Rin, Rout  out  1 each  select/encode controls.
- R0_15_in_enable_out  out  NREG  direct register write enable; only bit 15 is ever driven (jal).

Behaviour:
- Outputs are a combinational decode of the state register and the latched class.
- States: S_RESET, T0–T7, S_PAUSE, S_HALT.
- Reset: clr high at any edge, including mid-instruction, forces S_RESET. All outputs are 0 in S_RESET. The next state is T0.
- Fetch:
  - T0: PCout, MAR_enable, IncPC, PC_enable.
  - T1: Read, MDR_enable.
  - T2: MDRout, IR_enable.
  - T2 always proceeds to T3.
- Decode: at T3, opcode is decoded into a class register used for T4–T7.
- Opcodes 0..27: ld ldi st add sub and or shr shra shl ror rol addi andi ori mul div neg not br jr jal in out mfhi mflo nop halt. Values 28–31 behave as nop.
- Execute steps per class:
  - R-type (add..rol): T3 Grb,Rout,Y_enable; T4 Grc,Rout,Z_enable; T5 ZLowout,Gra,Rin.
  - I-type (addi/andi/ori): same as R-type, except T4 uses Cout instead of Grc,Rout.
  - neg/not: T3 Grb,Rout,Z_enable; T4 ZLowout,Gra,Rin.
  - mul/div: T3 Gra,Rout,Y_enable; T4 Grb,Rout,Z_enable; T5 ZLowout,LO_enable; T6 ZHighout,HI_enable.
  - ld: T3 Grb,BAout,Y_enable; T4 Cout,Z_enable; T5 ZLowout,MAR_enable; T6 Read,MDR_enable; T7 MDRout,Gra,Rin.
  - ldi: same T3–T4 as ld; T5 ZLowout,Gra,Rin; then ends.
  - st: ld T3–T5; T6 Gra,Rout,MDR_enable (Read=0); T7 Write.
  - br: T3 Gra,Rout,CONin; T4 PCout,Y_enable; T5 Cout,Z_enable; T6 ZLowout,PC_enable only if con_ff=1, otherwise no strobes.
  - jr: T3 Gra,Rout,PC_enable.
  - jal: T3 PCout, R0_15_in_enable_out[15]; T4 Gra,Rout,PC_enable.
  - in: T3 InPortout,Gra,Rin.
  - out: T3 Gra,Rout,OutPort_enable.
  - mfhi: T3 HIout,Gra,Rin.
  - mflo: T3 LOout,Gra,Rin.
  - nop: T3 no strobes.
- End of instruction: the last step goes to T0, or to S_PAUSE if stop=1 at that edge.
- S_PAUSE: all outputs 0; returns to T0 on the first edge with stop=0.
- halt: T3 goes to S_HALT. S_HALT holds, with all outputs 0 and run=0, until clr.
- stop mid-instruction never truncates the instruction.
- Exactly one bus source is active in any state.

Optional Feature:
- Macro CU_MEM_WAIT_EN.
- Defined: adds input mem_ready (1 bit). Any state asserting Read or Write (T1; ld T6; st T7) holds, with its outputs stable, until mem_ready=1, then advances.
- Undefined: no port; memory steps are single-cycle.

Decomposition:
- Package cpu_pkg:
  - opcode localparams (OP_LD=0 … OP_HALT=27);
  - state encoding;
  - class enum (C_RTYPE, C_ITYPE, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT).
- One sub-module, cu_opclass, maps opcode to class; it is purely combinational.

Test Plan:
- clr=1 at T4 of add, then released → S_RESET cycle with all outputs 0, then T0 with PCout=MAR_enable=IncPC=PC_enable=1.
- opcode=3 (add) → 6 cycles T0..T5; T4 has Grc=Rout=Z_enable=1; T5 has ZLowout=Gra=Rin=1; back to T0.
- opcode=0 (ld) → 8 cycles; T6 Read=MDR_enable=1; T7 MDRout=Gra=Rin=1.
- opcode=19 (br), con_ff=0 then con_ff=1 → T6 has PC_enable=0 then PC_enable=1 with ZLowout=1.
- opcode=21 (jal) → T3 R0_15_in_enable_out=16'h8000 with PCout; T4 PC_enable=1.
- opcode=27 (halt) → S_HALT, run=0 held 20 cycles; stop pulse at mul T4 completes T6, then S_PAUSE until stop=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode values, sequencer state encoding and instruction classes for the CPU control unit.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    typedef enum logic [3:0] {
        S_RESET, T0, T1, T2, T3, T4, T5, T6, T7, S_PAUSE, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_ITYPE, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } op_class_t;

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the datapath; mem_ready exists only with CU_MEM_WAIT_EN.
interface control_unit_if #(
    parameter int OPW  = 5,
    parameter int NREG = 16
);
    logic [OPW-1:0]  opcode;
    logic            con_ff;
    logic            stop;
`ifdef CU_MEM_WAIT_EN
    logic            mem_ready;
`endif
    logic            run;
    logic            Read, Write, IncPC, CONin;
    logic            PC_enable, Z_enable, MDR_enable, MAR_enable, Y_enable;
    logic            HI_enable, LO_enable, IR_enable, OutPort_enable;
    logic            PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout, BAout;
    logic            Gra, Grb, Grc, Rin, Rout;
    logic [NREG-1:0] R0_15_in_enable_out;

    modport master (
`ifdef CU_MEM_WAIT_EN
        input  mem_ready,
`endif
        input  opcode, con_ff, stop,
        output run, Read, Write, IncPC, CONin,
        output PC_enable, Z_enable, MDR_enable, MAR_enable, Y_enable,
        output HI_enable, LO_enable, IR_enable, OutPort_enable,
        output PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout, BAout,
        output Gra, Grb, Grc, Rin, Rout, R0_15_in_enable_out
    );

    modport slave (
`ifdef CU_MEM_WAIT_EN
        output mem_ready,
`endif
        output opcode, con_ff, stop,
        input  run, Read, Write, IncPC, CONin,
        input  PC_enable, Z_enable, MDR_enable, MAR_enable, Y_enable,
        input  HI_enable, LO_enable, IR_enable, OutPort_enable,
        input  PCout, ZHighout, ZLowout, HIout, LOout, MDRout, InPortout, Cout, BAout,
        input  Gra, Grb, Grc, Rin, Rout, R0_15_in_enable_out
    );
endinterface

// File: rtl/cu_opclass.sv
// Combinational opcode-to-class decoder; unassigned opcodes 28..31 fall into the nop class.
module cu_opclass
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output op_class_t      op_class
);

    always_comb begin
        op_class = C_NOP;
        case (opcode)
            OP_LD:                                   op_class = C_LD;
            OP_LDI:                                  op_class = C_LDI;
            OP_ST:                                   op_class = C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:         op_class = C_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:                op_class = C_ITYPE;
            OP_MUL, OP_DIV:                          op_class = C_MULDIV;
            OP_NEG, OP_NOT:                          op_class = C_UNARY;
            OP_BR:                                   op_class = C_BR;
            OP_JR:                                   op_class = C_JR;
            OP_JAL:                                  op_class = C_JAL;
            OP_IN:                                   op_class = C_IN;
            OP_OUT:                                  op_class = C_OUT;
            OP_MFHI:                                 op_class = C_MFHI;
            OP_MFLO:                                 op_class = C_MFLO;
            OP_HALT:                                 op_class = C_HALT;
            default:                                 op_class = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer driving every datapath control strobe: fetch T0-T2, per-class execute T3-T7.
// Optional macro CU_MEM_WAIT_EN stretches Read/Write steps until mem_ready.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int NREG = 16
) (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master bus
);

    state_t    state_q, state_d;
    op_class_t cls_q, cls_d, cls;
    logic      last, mem_ok;

    cu_opclass #(.OPW(OPW)) u_opclass (
        .opcode   (bus.opcode),
        .op_class (cls_d)
    );

`ifdef CU_MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    // T3 decodes straight from the opcode; later steps use the class captured at T3
    assign cls = (state_q == T3) ? cls_d : cls_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_RESET;
            cls_q   <= C_NOP;
        end else begin
            state_q <= state_d;
            if (state_q == T3)
                cls_q <= cls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last    = 1'b0;
        case (state_q)
            S_RESET: state_d = T0;
            T0:      state_d = T1;
            T1:      if (mem_ok) state_d = T2;
            T2:      state_d = T3;
            T3: begin
                if (cls == C_HALT)
                    state_d = S_HALT;
                else if (cls inside {C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP})
                    last = 1'b1;
                else
                    state_d = T4;
            end
            T4:      if (cls inside {C_UNARY, C_JAL}) last = 1'b1; else state_d = T5;
            T5:      if (cls inside {C_RTYPE, C_ITYPE, C_LDI}) last = 1'b1; else state_d = T6;
            T6: begin
                if (cls inside {C_MULDIV, C_BR})
                    last = 1'b1;
                else if (cls != C_LD || mem_ok)
                    state_d = T7;
            end
            T7:      if (cls != C_ST || mem_ok) last = 1'b1;
            S_PAUSE: if (!bus.stop) state_d = T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
        // stop is only honoured once the current instruction has fully retired
        if (last)
            state_d = bus.stop ? S_PAUSE : T0;
    end

    always_comb begin
        bus.run = !(state_q inside {S_RESET, S_PAUSE, S_HALT});
        bus.Read = 1'b0;      bus.Write = 1'b0;     bus.IncPC = 1'b0;     bus.CONin = 1'b0;
        bus.PC_enable = 1'b0; bus.Z_enable = 1'b0;  bus.MDR_enable = 1'b0;
        bus.MAR_enable = 1'b0; bus.Y_enable = 1'b0; bus.HI_enable = 1'b0;
        bus.LO_enable = 1'b0; bus.IR_enable = 1'b0; bus.OutPort_enable = 1'b0;
        bus.PCout = 1'b0;     bus.ZHighout = 1'b0;  bus.ZLowout = 1'b0;   bus.HIout = 1'b0;
        bus.LOout = 1'b0;     bus.MDRout = 1'b0;    bus.InPortout = 1'b0;
        bus.Cout = 1'b0;      bus.BAout = 1'b0;
        bus.Gra = 1'b0;       bus.Grb = 1'b0;       bus.Grc = 1'b0;       bus.Rin = 1'b0;
        bus.Rout = 1'b0;
        bus.R0_15_in_enable_out = '0;
        case (state_q)
            T0: begin bus.PCout = 1'b1; bus.MAR_enable = 1'b1; bus.IncPC = 1'b1; bus.PC_enable = 1'b1; end
            T1: begin bus.Read = 1'b1; bus.MDR_enable = 1'b1; end
            T2: begin bus.MDRout = 1'b1; bus.IR_enable = 1'b1; end
            T3: case (cls)
                C_RTYPE, C_ITYPE: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_enable = 1'b1; end
                C_UNARY:          begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_enable = 1'b1; end
                C_MULDIV:         begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Y_enable = 1'b1; end
                C_LD, C_LDI, C_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_enable = 1'b1; end
                C_BR:             begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                C_JR:             begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PC_enable = 1'b1; end
                C_JAL:            begin bus.PCout = 1'b1; bus.R0_15_in_enable_out[NREG-1] = 1'b1; end
                C_IN:             begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                C_OUT:            begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPort_enable = 1'b1; end
                C_MFHI:           begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                C_MFLO:           begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                default: ;
            endcase
            T4: case (cls)
                C_RTYPE:          begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Z_enable = 1'b1; end
                C_ITYPE, C_LD, C_LDI, C_ST: begin bus.Cout = 1'b1; bus.Z_enable = 1'b1; end
                C_UNARY:          begin bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                C_MULDIV:         begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Z_enable = 1'b1; end
                C_BR:             begin bus.PCout = 1'b1; bus.Y_enable = 1'b1; end
                C_JAL:            begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PC_enable = 1'b1; end
                default: ;
            endcase
            T5: case (cls)
                C_RTYPE, C_ITYPE, C_LDI: begin bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                C_MULDIV:         begin bus.ZLowout = 1'b1; bus.LO_enable = 1'b1; end
                C_LD, C_ST:       begin bus.ZLowout = 1'b1; bus.MAR_enable = 1'b1; end
                C_BR:             begin bus.Cout = 1'b1; bus.Z_enable = 1'b1; end
                default: ;
            endcase
            T6: case (cls)
                C_MULDIV:         begin bus.ZHighout = 1'b1; bus.HI_enable = 1'b1; end
                C_LD:             begin bus.Read = 1'b1; bus.MDR_enable = 1'b1; end
                C_ST:             begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDR_enable = 1'b1; end
                C_BR:             begin bus.ZLowout = bus.con_ff; bus.PC_enable = bus.con_ff; end
                default: ;
            endcase
            T7: case (cls)
                C_LD:             begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                C_ST:             bus.Write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit: a per-opcode table of expected step vectors drives a per-cycle compare.
module tb_control_unit;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    control_unit_if #(.OPW(5), .NREG(16)) bus ();
    control_unit #(.OPW(5), .NREG(16)) dut (.clk(clk), .clr(clr), .bus(bus));

    typedef logic [43:0] vec_t;
    localparam vec_t RUN    = 44'd1 << 43;
    localparam vec_t READ   = 44'd1 << 42;
    localparam vec_t WRITE  = 44'd1 << 41;
    localparam vec_t INCPC  = 44'd1 << 40;
    localparam vec_t CONIN  = 44'd1 << 39;
    localparam vec_t PCEN   = 44'd1 << 38;
    localparam vec_t ZEN    = 44'd1 << 37;
    localparam vec_t MDREN  = 44'd1 << 36;
    localparam vec_t MAREN  = 44'd1 << 35;
    localparam vec_t YEN    = 44'd1 << 34;
    localparam vec_t HIEN   = 44'd1 << 33;
    localparam vec_t LOEN   = 44'd1 << 32;
    localparam vec_t IREN   = 44'd1 << 31;
    localparam vec_t OUTEN  = 44'd1 << 30;
    localparam vec_t PCOUT  = 44'd1 << 29;
    localparam vec_t ZHI    = 44'd1 << 28;
    localparam vec_t ZLO    = 44'd1 << 27;
    localparam vec_t HIOUT  = 44'd1 << 26;
    localparam vec_t LOOUT  = 44'd1 << 25;
    localparam vec_t MDROUT = 44'd1 << 24;
    localparam vec_t INP    = 44'd1 << 23;
    localparam vec_t COUT   = 44'd1 << 22;
    localparam vec_t BAOUT  = 44'd1 << 21;
    localparam vec_t GRA    = 44'd1 << 20;
    localparam vec_t GRB    = 44'd1 << 19;
    localparam vec_t GRC    = 44'd1 << 18;
    localparam vec_t RIN    = 44'd1 << 17;
    localparam vec_t ROUT   = 44'd1 << 16;
    localparam vec_t R15    = 44'd1 << 15;
    localparam vec_t BUS_SRC = PCOUT | ZHI | ZLO | HIOUT | LOOUT | MDROUT | INP | COUT | BAOUT | ROUT;

    vec_t dut_vec;
    assign dut_vec = {bus.run, bus.Read, bus.Write, bus.IncPC, bus.CONin,
                      bus.PC_enable, bus.Z_enable, bus.MDR_enable, bus.MAR_enable, bus.Y_enable,
                      bus.HI_enable, bus.LO_enable, bus.IR_enable, bus.OutPort_enable,
                      bus.PCout, bus.ZHighout, bus.ZLowout, bus.HIout, bus.LOout, bus.MDRout,
                      bus.InPortout, bus.Cout, bus.BAout,
                      bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                      bus.R0_15_in_enable_out};

    vec_t  exp_vec;
    bit    exp_valid = 1'b0;
    string exp_tag = "";
    int    checks = 0;
    int    errors = 0;
    vec_t  exp_q[$];

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL %s: got %h expected %h", exp_tag, dut_vec, exp_vec);
            end
            checks++;
            if ($countones(dut_vec & BUS_SRC) > 1) begin
                errors++;
                $display("FAIL %s bus_sources: got %h expected at most one of %h", exp_tag, dut_vec & BUS_SRC, BUS_SRC);
            end
        end
    end

    // Expected control vector for every cycle of one instruction, fetch included.
    task automatic build_seq(input logic [4:0] op, input bit con);
        exp_q.delete();
        exp_q.push_back(RUN | PCOUT | MAREN | INCPC | PCEN);
        exp_q.push_back(RUN | READ | MDREN);
        exp_q.push_back(RUN | MDROUT | IREN);
        if (op <= 5'd2) begin
            exp_q.push_back(GRB | BAOUT | YEN);
            exp_q.push_back(COUT | ZEN);
            if (op == 5'd1) begin
                exp_q.push_back(ZLO | GRA | RIN);
            end else begin
                exp_q.push_back(ZLO | MAREN);
                if (op == 5'd0) begin
                    exp_q.push_back(READ | MDREN);
                    exp_q.push_back(MDROUT | GRA | RIN);
                end else begin
                    exp_q.push_back(GRA | ROUT | MDREN);
                    exp_q.push_back(WRITE);
                end
            end
        end else if (op <= 5'd14) begin
            exp_q.push_back(GRB | ROUT | YEN);
            exp_q.push_back((op >= 5'd12) ? (COUT | ZEN) : (GRC | ROUT | ZEN));
            exp_q.push_back(ZLO | GRA | RIN);
        end else if (op <= 5'd16) begin
            exp_q.push_back(GRA | ROUT | YEN);
            exp_q.push_back(GRB | ROUT | ZEN);
            exp_q.push_back(ZLO | LOEN);
            exp_q.push_back(ZHI | HIEN);
        end else if (op <= 5'd18) begin
            exp_q.push_back(GRB | ROUT | ZEN);
            exp_q.push_back(ZLO | GRA | RIN);
        end else begin
            case (op)
                5'd19: begin
                    exp_q.push_back(GRA | ROUT | CONIN);
                    exp_q.push_back(PCOUT | YEN);
                    exp_q.push_back(COUT | ZEN);
                    exp_q.push_back(con ? (ZLO | PCEN) : '0);
                end
                5'd20: exp_q.push_back(GRA | ROUT | PCEN);
                5'd21: begin
                    exp_q.push_back(PCOUT | R15);
                    exp_q.push_back(GRA | ROUT | PCEN);
                end
                5'd22: exp_q.push_back(INP | GRA | RIN);
                5'd23: exp_q.push_back(GRA | ROUT | OUTEN);
                5'd24: exp_q.push_back(HIOUT | GRA | RIN);
                5'd25: exp_q.push_back(LOOUT | GRA | RIN);
                default: exp_q.push_back('0);
            endcase
        end
        for (int i = 3; i < exp_q.size(); i++)
            exp_q[i] = exp_q[i] | RUN;
    endtask

    task automatic drive(input vec_t e, input string tag, input logic [4:0] op,
                         input bit con, input bit st, input bit rst);
        exp_vec   = e;
        exp_tag   = tag;
        exp_valid = 1'b1;
        bus.opcode = op;
        bus.con_ff = con;
        bus.stop   = st;
        clr        = rst;
        @(posedge clk);
        #1;
    endtask

    // One instruction: opcode is garbage until T3, stop is random until the final step.
    task automatic run_instr(input logic [4:0] op, input bit con, input bit stp,
                             input int pause_len, input int clr_at);
        vec_t seq[$];
        build_seq(op, con);
        seq = exp_q;
        for (int i = 0; i < seq.size(); i++) begin
            logic [4:0] dop;
            bit s;
            dop = (i >= 3) ? op : 5'($urandom);
            s = (i == seq.size() - 1) ? stp : 1'($urandom);
            if (i == clr_at) begin
                drive(seq[i], $sformatf("op%0d step%0d clr", op, i), dop, con, s, 1'b1);
                drive('0, "reset_mid_instr", 5'($urandom), con, 1'b0, 1'b0);
                return;
            end
            drive(seq[i], $sformatf("op%0d step%0d", op, i), dop, con, s, 1'b0);
        end
        if (stp && op != 5'd27) begin
            for (int k = 0; k < pause_len; k++)
                drive('0, $sformatf("pause%0d", k), 5'($urandom), 1'($urandom), k < pause_len - 1, 1'b0);
        end
    endtask

    task automatic pin_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic pin_vec(input string name, input vec_t got, input vec_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    initial begin
        clr = 1'b1;
        bus.opcode = '0;
        bus.con_ff = 1'b0;
        bus.stop   = 1'b0;
`ifdef CU_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        @(posedge clk);
        #1;

        build_seq(5'd3, 1'b0);
        pin_int("model_add_len", exp_q.size(), 6);
        pin_vec("model_add_T4", exp_q[4], 44'h820_0005_0000);
        build_seq(5'd0, 1'b0);
        pin_int("model_ld_len", exp_q.size(), 8);
        build_seq(5'd19, 1'b1);
        pin_vec("model_br_taken_T6", exp_q[6], 44'h840_0800_0000);
        build_seq(5'd19, 1'b0);
        pin_vec("model_br_not_taken_T6", exp_q[6], 44'h800_0000_0000);
        build_seq(5'd21, 1'b0);
        pin_vec("model_jal_T3", exp_q[3], 44'h800_2000_8000);

        drive('0, "reset_hold", 5'd0, 1'b0, 1'b0, 1'b1);
        drive('0, "reset_release", 5'd0, 1'b0, 1'b0, 1'b0);

        run_instr(5'd3, 1'b0, 1'b0, 0, 4);
        run_instr(5'd3, 1'b0, 1'b0, 0, -1);
        run_instr(5'd0, 1'b0, 1'b0, 0, -1);
        run_instr(5'd19, 1'b0, 1'b0, 0, -1);
        run_instr(5'd19, 1'b1, 1'b0, 0, -1);
        run_instr(5'd21, 1'b0, 1'b0, 0, -1);
        run_instr(5'd15, 1'b0, 1'b1, 3, -1);
        run_instr(5'd2, 1'b1, 1'b1, 1, -1);

        for (int op = 0; op < 32; op++)
            if (op != 27)
                run_instr(5'(op), 1'($urandom), 1'b0, 0, -1);

        repeat (150) begin
            logic [4:0] rop;
            rop = 5'($urandom);
            if (rop == 5'd27)
                rop = 5'd26;
            run_instr(rop, 1'($urandom), ($urandom_range(0, 3) == 0),
                      int'($urandom_range(1, 4)), ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : -1);
        end

        run_instr(5'd27, 1'b0, 1'b0, 0, -1);
        repeat (20)
            drive('0, "halt_hold", 5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        drive('0, "halt_clr", 5'($urandom), 1'b0, 1'b0, 1'b1);
        drive('0, "reset_after_halt", 5'($urandom), 1'b0, 1'b0, 1'b0);
        run_instr(5'd4, 1'b0, 1'b0, 0, -1);

        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
